note_player: RTL and testbench

- Consumer end of the CPU's PLY note interface.
- Accepts note commands (period count plus beat count) through a valid/ready handshake and queues them in a small FIFO.
- Plays each note as a square-wave PCM sample stream, timed by a BPM-driven beat generator, with a silent articulation gap between notes.
- Sits between the exe stage (PLY issue) and the audio codec serializer.

---
 rtl/audio_pkg.sv | 30 +++
 rtl/note_fifo.sv | 69 ++++++
 rtl/note_player.sv | 183 ++++++++++++++++++
 tb/tb_note_player.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared audio definitions for the PLY note path.
//   - note period constants in clk cycles at 50 MHz (c_low = C4 ... f_high = F5)
//   - play_state_t : note player sequencing states
//   - note_cmd_t   : one queued note command (period + beat count), 24 bits
package audio_pkg;

   localparam logic [20:0] c_low  = 21'd191117;
   localparam logic [20:0] d_low  = 21'd170265;
   localparam logic [20:0] e_low  = 21'd151685;
   localparam logic [20:0] f_low  = 21'd143172;
   localparam logic [20:0] g_low  = 21'd127551;
   localparam logic [20:0] a_low  = 21'd113636;
   localparam logic [20:0] b_low  = 21'd101239;
   localparam logic [20:0] c_high = 21'd95557;
   localparam logic [20:0] d_high = 21'd85131;
   localparam logic [20:0] e_high = 21'd75843;
   localparam logic [20:0] f_high = 21'd71586;

   typedef enum logic [1:0] {
      IDLE,
      TONE,
      GAP
   } play_state_t;

   typedef struct packed {
      logic [20:0] period;
      logic [2:0]  beats;
   } note_cmd_t;

endpackage

// File: rtl/note_fifo.sv
// Circular queue of note commands.
// Ports:
//   clk, rst_n     clock, async active-low reset
//   clear          synchronous empty (drops every entry)
//   push, din      write request and 24-bit entry
//   pop, dout      read request; dout shows the head entry whenever not empty
//   count          number of stored entries
//   full, empty    occupancy flags
// A push while full is taken only when a pop happens in the same cycle.
module note_fifo #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clear,
   input  logic                     push,
   input  logic [23:0]              din,
   input  logic                     pop,
   output logic [23:0]              dout,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [23:0]      mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (PTR_W+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push && !clear) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (do_push && !do_pop) begin
            count <= count + 1'b1;
         end else if (do_pop && !do_push) begin
            count <= count - 1'b1;
         end
      end
   end

endmodule

// File: rtl/note_player.sv
// Note player: queues PLY note commands and plays each one as a square-wave
// PCM stream timed by a BPM-driven beat accumulator, followed by a silent gap.
// Ports:
//   clk, rst_n               clock, async active-low reset
//   note_valid/note_ready    command handshake (beats==0 is accepted and dropped)
//   note_period, note_beats  square-wave period in clk cycles, length in beats
//   bpm                      tempo, used live (0 behaves as 1)
//   sample_out               signed 16-bit PCM sample
//   playing                  a note or its gap is being output
//   fifo_count               queued commands
//   idle                     nothing playing and nothing queued
//   flush                    only with NOTE_PLAYER_FLUSH_EN defined: drops the
//                            queue and the current note
//
// state | meaning
// IDLE  | silent; pops the next command when the queue is non-empty
// TONE  | square wave for beats_left beats
// GAP   | silent articulation gap, GAP_CYCLES cycles
//
// sample_out/playing/idle are registered from the state the FSM was in
// before the edge, so the audible note starts one edge after the pop.
module note_player
   import audio_pkg::*;
#(
   parameter int CLK_HZ     = 50000000,
   parameter int FIFO_DEPTH = 4,
   parameter int AMPLITUDE  = 8000,
   parameter int GAP_CYCLES = 500000
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          note_valid,
   output logic                          note_ready,
   input  logic [20:0]                   note_period,
   input  logic [2:0]                    note_beats,
   input  logic [10:0]                   bpm,
`ifdef NOTE_PLAYER_FLUSH_EN
   input  logic                          flush,
`endif
   output logic [15:0]                   sample_out,
   output logic                          playing,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          idle
);

   localparam logic [63:0]        BEAT_LIMIT = 64'(CLK_HZ) * 64'd60;
   localparam int                 ACC_W      = $clog2(BEAT_LIMIT + 64'd2048);
   localparam logic [ACC_W-1:0]   LIMIT_W    = ACC_W'(BEAT_LIMIT);
   localparam int                 GAP_W      = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [GAP_W-1:0]   GAP_LOAD   = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;
   localparam logic [15:0]        AMP_POS    = 16'(AMPLITUDE);
   localparam logic [15:0]        AMP_NEG    = 16'(-AMPLITUDE);

   play_state_t      state;
   note_cmd_t        wr_cmd;
   note_cmd_t        rd_cmd;
   logic [23:0]      rd_raw;
   logic             fifo_push;
   logic             fifo_pop;
   logic             fifo_full;
   logic             fifo_empty;
   logic             flush_i;

   logic [20:0]      period;
   logic [20:0]      ph;
   logic [2:0]       beats_left;
   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] acc_sum;
   logic [10:0]      bpm_eff;
   logic             beat_tick;
   logic [GAP_W-1:0] gap_cnt;
   logic [15:0]      tone_level;

`ifdef NOTE_PLAYER_FLUSH_EN
   assign flush_i = flush;
`else
   assign flush_i = 1'b0;
`endif

   assign note_ready = ~fifo_full & ~flush_i;
   assign wr_cmd     = {note_period, note_beats};
   assign fifo_push  = note_valid & note_ready & (note_beats != 3'd0);
   assign fifo_pop   = (state == IDLE) & ~fifo_empty & ~flush_i;
   assign rd_cmd     = note_cmd_t'(rd_raw);

   note_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (flush_i),
      .push  (fifo_push),
      .din   (wr_cmd),
      .pop   (fifo_pop),
      .dout  (rd_raw),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Beat accumulator: one tick each time acc crosses CLK_HZ*60; the
   // remainder carries to the next beat so average beat length is exact.
   assign bpm_eff   = (bpm == 11'd0) ? 11'd1 : bpm;
   assign acc_sum   = acc + ACC_W'(bpm_eff);
   assign beat_tick = (state == TONE) && (acc_sum >= LIMIT_W);

   always_comb begin
      tone_level = '0;
      if (period >= 21'd2) begin
         tone_level = (ph < (period >> 1)) ? AMP_POS : AMP_NEG;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         period     <= '0;
         ph         <= '0;
         beats_left <= '0;
         acc        <= '0;
         gap_cnt    <= '0;
         sample_out <= '0;
         playing    <= 1'b0;
         idle       <= 1'b1;
      end else if (flush_i) begin
         state      <= IDLE;
         period     <= '0;
         ph         <= '0;
         beats_left <= '0;
         acc        <= '0;
         gap_cnt    <= '0;
         sample_out <= '0;
         playing    <= 1'b0;
         idle       <= 1'b1;
      end else begin
         sample_out <= (state == TONE) ? tone_level : 16'd0;
         playing    <= (state == TONE) || (state == GAP);
         idle       <= (state == IDLE) && fifo_empty;

         case (state)
            IDLE: begin
               if (!fifo_empty) begin
                  period     <= rd_cmd.period;
                  beats_left <= rd_cmd.beats;
                  ph         <= '0;
                  acc        <= '0;
                  state      <= TONE;
               end
            end

            TONE: begin
               // Written as ph+1 >= period so periods 0 and 1 stay bounded.
               ph  <= ((ph + 21'd1) >= period) ? 21'd0 : ph + 21'd1;
               acc <= beat_tick ? (acc_sum - LIMIT_W) : acc_sum;
               if (beat_tick) begin
                  if (beats_left == 3'd1) begin
                     beats_left <= '0;
                     if (GAP_CYCLES == 0) begin
                        state <= IDLE;
                     end else begin
                        gap_cnt <= GAP_LOAD;
                        state   <= GAP;
                     end
                  end else begin
                     beats_left <= beats_left - 3'd1;
                  end
               end
            end

            GAP: begin
               if (gap_cnt == '0) begin
                  state <= IDLE;
               end else begin
                  gap_cnt <= gap_cnt - 1'b1;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_note_player.sv
module tb_note_player;

   localparam int CLK_HZ = 600;
   localparam int DEPTH  = 4;
   localparam int AMP    = 8000;
   localparam int GAP_C  = 10;
   localparam int LIMIT  = CLK_HZ * 60;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        note_valid = 1'b0;
   logic [20:0] note_period = '0;
   logic [2:0]  note_beats = '0;
   logic [10:0] bpm = 11'd60;
   logic        flush = 1'b0;
   logic        note_ready;
   logic [15:0] sample_out;
   logic        playing;
   logic [2:0]  fifo_count;
   logic        idle;

   note_player #(
      .CLK_HZ     (CLK_HZ),
      .FIFO_DEPTH (DEPTH),
      .AMPLITUDE  (AMP),
      .GAP_CYCLES (GAP_C)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .note_valid  (note_valid),
      .note_ready  (note_ready),
      .note_period (note_period),
      .note_beats  (note_beats),
      .bpm         (bpm),
`ifdef NOTE_PLAYER_FLUSH_EN
      .flush       (flush),
`endif
      .sample_out  (sample_out),
      .playing     (playing),
      .fifo_count  (fifo_count),
      .idle        (idle)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference: each accepted note becomes an interval on the edge timeline.
   typedef struct {
      int acc_edge;
      int start;
      int dur;
      int period;
   } mnote_t;

   mnote_t notes[$];
   int     free_at = -100000;
   int     n_checks = 0;
   int     n_fail = 0;
   bit     chk_en = 1'b0;

   task automatic check_val(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic int m_count(input int t);
      int c = 0;
      foreach (notes[i]) if (notes[i].acc_edge <= t && t < notes[i].start - 1) c++;
      return c;
   endfunction

   function automatic int m_playing(input int t);
      foreach (notes[i]) if (notes[i].start <= t && t < notes[i].start + notes[i].dur + GAP_C) return 1;
      return 0;
   endfunction

   function automatic int m_sample(input int t);
      foreach (notes[i]) begin
         if (notes[i].start <= t && t < notes[i].start + notes[i].dur) begin
            int k = t - notes[i].start;
            if (notes[i].period < 2) return 0;
            return ((k % notes[i].period) < (notes[i].period / 2)) ? AMP : -AMP;
         end
      end
      return 0;
   endfunction

   function automatic int m_idle(input int t);
      return (m_playing(t) == 0 && m_count(t - 1) == 0) ? 1 : 0;
   endfunction

   function automatic void m_accept(input int n, input int per, input int bts);
      int be;
      int d;
      int s;
      if (bts == 0) return;
      be = (bpm == 0) ? 1 : int'(bpm);
      d  = (bts * LIMIT + be - 1) / be;
      s  = (n + 2 > free_at + 1) ? n + 2 : free_at + 1;
      notes.push_back('{n, s, d, per});
      free_at = s + d + GAP_C;
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         check_val("sample_out", int'($signed(sample_out)), m_sample(cyc));
         check_val("playing", int'(playing), m_playing(cyc));
         check_val("fifo_count", int'(fifo_count), m_count(cyc));
         check_val("idle", int'(idle), m_idle(cyc));
         check_val("note_ready", int'(note_ready), (!flush && m_count(cyc) < DEPTH) ? 1 : 0);
      end
   end

   task automatic do_reset();
      chk_en = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      note_valid = 1'b0;
      flush = 1'b0;
      #1;
      check_val("rst_sample", int'($signed(sample_out)), 0);
      check_val("rst_playing", int'(playing), 0);
      check_val("rst_count", int'(fifo_count), 0);
      check_val("rst_idle", int'(idle), 1);
      check_val("rst_ready", int'(note_ready), 1);
      notes.delete();
      free_at = -100000;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk_en = 1'b1;
   endtask

   // Holds valid until the reference says the queue has room; returns the accept edge.
   task automatic push_note(input int per, input int bts, output int acc_edge);
      acc_edge = -1;
      note_valid = 1'b1;
      note_period = 21'(per);
      note_beats = 3'(bts);
      for (int w = 0; w < 5000; w++) begin
         if (m_count(cyc) < DEPTH) begin
            acc_edge = cyc + 1;
            m_accept(acc_edge, per, bts);
            @(posedge clk); #1;
            note_valid = 1'b0;
            return;
         end
         @(posedge clk); #1;
      end
      note_valid = 1'b0;
      check_val("push_timeout", 0, 1);
   endtask

   task automatic wait_playing();
      for (int w = 0; w < 200; w++) begin
         if (playing) return;
         @(posedge clk); #1;
      end
      check_val("wait_playing_timeout", 0, 1);
   endtask

   task automatic wait_drain();
      for (int w = 0; w < 30000; w++) begin
         if (cyc >= free_at) begin
            check_val("drain_idle", int'(idle), 1);
            return;
         end
         @(posedge clk); #1;
      end
      check_val("drain_timeout", 0, 1);
   endtask

   // Measures one audible note: start edge, tone edges, silent gap edges.
   // If switch_at > 0, bpm is changed to new_bpm after that many tone edges.
   task automatic measure_note(input int switch_at, input int new_bpm,
                               output int s, output int tone_len, output int gap_len);
      s = -1;
      tone_len = 0;
      gap_len = 0;
      for (int w = 0; w < 200; w++) begin
         if (playing) begin
            s = cyc;
            break;
         end
         @(posedge clk); #1;
      end
      if (s < 0) begin
         check_val("note_start_timeout", 0, 1);
         return;
      end
      while (playing && sample_out != 16'd0 && tone_len < 60000) begin
         tone_len++;
         if (switch_at > 0 && tone_len == switch_at) bpm = 11'(new_bpm);
         @(posedge clk); #1;
      end
      while (playing && sample_out == 16'd0 && gap_len < 1000) begin
         gap_len++;
         @(posedge clk); #1;
      end
   endtask

   initial begin
      int a;
      int s;
      int tl;
      int gl;
      int plen;
      int nz;

      // 1: single note, 600 cycles/beat, period 8
      bpm = 11'd60;
      do_reset();
      push_note(8, 2, a);
      measure_note(0, 0, s, tl, gl);
      check_val("t1_latency", s - a, 2);
      check_val("t1_tone_len", tl, 2 * LIMIT / 60);
      check_val("t1_gap_len", gl, GAP_C);
      check_val("t1_idle", int'(idle), 1);

      // 2: fill queue while playing, fifth push waits for a pop
      do_reset();
      bpm = 11'd600;
      push_note(10, 3, a);
      wait_playing();
      for (int i = 0; i < DEPTH; i++) push_note(4 + 2 * i, 1, a);
      check_val("t2_full_count", int'(fifo_count), DEPTH);
      check_val("t2_full_ready", int'(note_ready), 0);
      push_note(6, 2, a);
      check_val("t2_fifth_held", (a > notes[0].start + 100) ? 1 : 0, 1);
      check_val("t2_count_after", int'(fifo_count), DEPTH);
      wait_drain();

      // 3: zero-beat command is swallowed
      do_reset();
      push_note(8, 0, a);
      repeat (3) @(posedge clk);
      #1;
      check_val("t3_count", int'(fifo_count), 0);
      check_val("t3_idle", int'(idle), 1);
      check_val("t3_sample", int'($signed(sample_out)), 0);
      check_val("t3_playing", int'(playing), 0);

      // 4: bpm 0 acts as 1, then 120 for the second beat
      do_reset();
      chk_en = 1'b0;
      bpm = 11'd0;
      note_valid = 1'b1;
      note_period = 21'd8;
      note_beats = 3'd2;
      @(posedge clk); #1;
      note_valid = 1'b0;
      measure_note(LIMIT, 120, s, tl, gl);
      check_val("t4_tone_len", tl, LIMIT + (LIMIT + 119) / 120);
      check_val("t4_gap_len", gl, GAP_C);
      check_val("t4_idle", int'(idle), 1);

      // 5: period 1 plays silence for the note length
      bpm = 11'd60;
      do_reset();
      push_note(1, 1, a);
      wait_playing();
      plen = 0;
      nz = 0;
      while (playing && plen < 2000) begin
         plen++;
         if (sample_out != 16'd0) nz++;
         @(posedge clk); #1;
      end
      check_val("t5_play_len", plen, LIMIT / 60 + GAP_C);
      check_val("t5_nonzero", nz, 0);

      // reset in the middle of a note with entries queued
      do_reset();
      bpm = 11'd600;
      push_note(8, 3, a);
      push_note(8, 3, a);
      push_note(8, 3, a);
      wait_playing();
      repeat (20) @(posedge clk);
      do_reset();

      // random traffic against the reference
      for (int r = 0; r < 2; r++) begin
         do_reset();
         bpm = 11'($urandom_range(600, 2047));
         for (int i = 0; i < 25; i++) begin
            repeat ($urandom_range(0, 30)) @(posedge clk);
            #1;
            push_note($urandom_range(0, 20), $urandom_range(0, 7), a);
         end
         wait_drain();
      end

`ifdef NOTE_PLAYER_FLUSH_EN
      // 6: flush mid-tone with a simultaneous push
      do_reset();
      bpm = 11'd600;
      push_note(9, 7, a);
      wait_playing();
      for (int i = 0; i < 3; i++) push_note(5, 2, a);
      repeat (20) @(posedge clk);
      #1;
      check_val("t6_pre_count", int'(fifo_count), 3);
      flush = 1'b1;
      note_valid = 1'b1;
      note_period = 21'd5;
      note_beats = 3'd2;
      @(posedge clk); #1;
      notes.delete();
      free_at = cyc;
      flush = 1'b0;
      note_valid = 1'b0;
      check_val("t6_count", int'(fifo_count), 0);
      check_val("t6_sample", int'($signed(sample_out)), 0);
      check_val("t6_idle", int'(idle), 1);
      check_val("t6_playing", int'(playing), 0);
      repeat (5) @(posedge clk);
      #1;
      check_val("t6_push_dropped", int'(fifo_count), 0);
      check_val("t6_still_idle", int'(idle), 1);
`endif

      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $fatal(1, "watchdog");
   end

endmodule
